// File: rtl/debounce_pkg.sv
// -----------------------------------------------------------------------------
// debounce_pkg
// Shared types and constants for the debounce_sync block.
//   db_state_t    : 2-bit filter state (LOW_STABLE=0, CHECK_HIGH=1,
//                   HIGH_STABLE=2, CHECK_LOW=3)
//   DB_SYNC_MIN   : smallest legal synchroniser depth
//   DB_SYNC_MAX   : largest legal synchroniser depth
//   DB_STABLE_MIN : smallest legal stability window
//   DB_STABLE_MAX : largest legal stability window
// -----------------------------------------------------------------------------
package debounce_pkg;

  typedef enum logic [1:0] {
    LOW_STABLE  = 2'd0,
    CHECK_HIGH  = 2'd1,
    HIGH_STABLE = 2'd2,
    CHECK_LOW   = 2'd3
  } db_state_t;

  localparam int DB_SYNC_MIN   = 2;
  localparam int DB_SYNC_MAX   = 4;
  localparam int DB_STABLE_MIN = 2;
  localparam int DB_STABLE_MAX = 65535;

endpackage

// File: rtl/sync_chain.sv
// -----------------------------------------------------------------------------
// sync_chain
// Plain shift chain of STAGES flops used to bring an asynchronous level into
// the clk domain. Each stage is a synchronous-reset D flop; nothing sits
// between stages so the metastability settling time is a full clock period.
// Ports:
//   clk   : system clock, rising edge
//   reset : synchronous active-high reset, clears every stage
//   d     : raw asynchronous input
//   q     : output of the last stage
// -----------------------------------------------------------------------------
module sync_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] r_chain;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_chain <= '0;
    end else begin
      r_chain <= {r_chain[STAGES-2:0], d};
    end
  end

  assign q = r_chain[STAGES-1];

endmodule

// File: rtl/debounce_sync.sv
// -----------------------------------------------------------------------------
// debounce_sync
// Synchronises a bouncy external level and only lets it through once it has
// been seen unchanged for STABLE_CYCLES consecutive synchronised samples.
// Produces a registered clean level plus single-cycle edge pulses.
//
// Optional feature (macro DEBOUNCE_TOGGLE_EN): adds output `toggle`, a
// push-on/push-off level that inverts on every rise pulse.
//
// Ports:
//   clk       : system clock, rising edge
//   reset     : synchronous active-high reset (no pulse is produced by it)
//   d_in      : raw asynchronous level
//   q         : debounced level, registered
//   rise      : one-cycle pulse when q goes 0->1
//   fall      : one-cycle pulse when q goes 1->0
//   dbg_state : current filter state, for observation only
//   toggle    : (DEBOUNCE_TOGGLE_EN only) inverts together with rise
// -----------------------------------------------------------------------------
module debounce_sync
  import debounce_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 4
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      d_in,
  output logic      q,
  output logic      rise,
  output logic      fall,
  output db_state_t dbg_state
`ifdef DEBOUNCE_TOGGLE_EN
  ,
  output logic      toggle
`endif
);

  localparam int CNT_W = $clog2(STABLE_CYCLES);
  // Last count value before the window completes; the counter stops here.
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // Elaboration-time parameter range checks.
  if (SYNC_STAGES < DB_SYNC_MIN || SYNC_STAGES > DB_SYNC_MAX) begin : g_bad_sync
    $error("debounce_sync: SYNC_STAGES out of range");
  end
  if (STABLE_CYCLES < DB_STABLE_MIN || STABLE_CYCLES > DB_STABLE_MAX) begin : g_bad_stable
    $error("debounce_sync: STABLE_CYCLES out of range");
  end

  logic             w_s;
  db_state_t        r_state;
  db_state_t        w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_q;
  logic             r_rise;
  logic             r_fall;
  logic             w_q_nxt;
  logic             w_rise_nxt;
  logic             w_fall_nxt;

  sync_chain #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (d_in),
    .q     (w_s)
  );

  // State register: filter state, counter and all registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= LOW_STABLE;
      r_cnt   <= '0;
      r_q     <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_q     <= w_q_nxt;
      r_rise  <= w_rise_nxt;
      r_fall  <= w_fall_nxt;
    end
  end

  // Next-state: the counter holds how many matching samples have been seen
  // in the current check, so entering a check starts at 1.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      LOW_STABLE: begin
        if (w_s) begin
          w_state_nxt = CHECK_HIGH;
          w_cnt_nxt   = CNT_ONE;
        end
      end
      CHECK_HIGH: begin
        if (!w_s) begin
          w_state_nxt = LOW_STABLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_MAX) begin
          w_state_nxt = HIGH_STABLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt   = r_cnt + CNT_ONE;
        end
      end
      HIGH_STABLE: begin
        if (!w_s) begin
          w_state_nxt = CHECK_LOW;
          w_cnt_nxt   = CNT_ONE;
        end
      end
      CHECK_LOW: begin
        if (w_s) begin
          w_state_nxt = HIGH_STABLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_MAX) begin
          w_state_nxt = LOW_STABLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt   = r_cnt + CNT_ONE;
        end
      end
      default: begin
        w_state_nxt = LOW_STABLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Output logic: pulses fire only on the edge that completes a check, so
  // rise and fall are mutually exclusive and last one cycle.
  always_comb begin
    w_rise_nxt = (r_state == CHECK_HIGH) && w_s && (r_cnt == CNT_MAX);
    w_fall_nxt = (r_state == CHECK_LOW) && !w_s && (r_cnt == CNT_MAX);
    w_q_nxt    = r_q;
    if (w_rise_nxt) begin
      w_q_nxt = 1'b1;
    end else if (w_fall_nxt) begin
      w_q_nxt = 1'b0;
    end
  end

  assign q         = r_q;
  assign rise      = r_rise;
  assign fall      = r_fall;
  assign dbg_state = r_state;

`ifdef DEBOUNCE_TOGGLE_EN
  logic r_toggle;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_toggle <= 1'b0;
    end else if (w_rise_nxt) begin
      r_toggle <= ~r_toggle;
    end
  end

  assign toggle = r_toggle;
`endif

endmodule
